audio_burst_wr_ctrl: RTL
========================

Name: audio_burst_wr_ctrl

Overview:
Memory-side sequencer that drains the audio write burst FIFO into a circular PCM buffer in external memory. It waits for a full burst to be available, then issues one write command and streams exactly BURST_LEN beats from the FIFO's first-word-fall-through (FWFT) output. It maintains the ring write pointer and stalls when the buffer would overrun the consumer's read pointer. It sits in the memory clock domain, between the burst FIFO read side and the memory write arbiter port.

Parameters:
BURST_LEN, 16, beats per burst; equals `MEM_WR_BL.
DSIZE, 36, memory data width in bits; equals `DSIZE.
ADDR_W, 21, memory word address width.
PTR_W, 10, ring pointer width in bursts; ring holds up to 2^PTR_W bursts.

Ports:
clk  in  1  memory-domain clock
rst_n  in  1  synchronous active-low reset
enable  in  1  level; start/continue draining
base_addr  in  ADDR_W  ring base word address; sampled while IDLE and enable=0
ring_bursts  in  PTR_W  ring size in bursts; valid range 2..2^PTR_W-1; sampled as base_addr
rd_ptr_i  in  PTR_W  consumer read pointer in bursts
burst_avail  in  1  FIFO holds >= BURST_LEN words
burst_rd_en  out  1  FIFO pop
burst_rd_data  in  DSIZE  FIFO FWFT data
mem_cmd_vld  out  1  write command valid
mem_cmd_rdy  in  1  write command accept
mem_cmd_addr  out  ADDR_W  burst start word address
mem_wr_vld  out  1  write data valid
mem_wr_rdy  in  1  write data accept
mem_wr_data  out  DSIZE  write data
mem_wr_last  out  1  final beat of burst
wr_ptr_o  out  PTR_W  ring write pointer in bursts (next burst slot)
busy  out  1  state != IDLE
err_ring_full  out  1  sticky; set when stalled on full ring

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; wr_ptr_o=0; beat count=0; all outputs 0, including err_ring_full. Latched base/size registers reset to 0.
- Ring full when (wr_ptr_o+1) mod ring_bursts == rd_ptr_i.
- States:
  - IDLE: if enable & burst_avail & !full -> CMD next cycle. If enable & burst_avail & full -> stay and set err_ring_full.
  - CMD: mem_cmd_vld=1 and mem_cmd_addr = base + wr_ptr_o*BURST_LEN, both held stable until mem_cmd_rdy. The multiply is a shift; BURST_LEN must be a power of two. On accept -> DATA.
  - DATA: mem_wr_vld=1; mem_wr_data=burst_rd_data (combinational passthrough, zero latency); burst_rd_en = mem_wr_rdy. The beat counter increments on each accepted beat. mem_wr_last=1 when count==BURST_LEN-1. The last accepted beat -> ADV.
  - ADV: one cycle. wr_ptr_o <= (wr_ptr_o == ring_bursts-1) ? 0 : wr_ptr_o+1. Counter cleared. -> IDLE.
- Minimum gap: IDLE->CMD->DATA->ADV->IDLE, so at least 3 overhead cycles per burst. Bursts are never back-to-back.
- burst_rd_en is asserted only in DATA with mem_wr_rdy. The block never pops more than BURST_LEN words per command.
- enable deasserted mid-burst: the current burst completes through ADV, then the block stays in IDLE.
- base_addr and ring_bursts are sampled only while IDLE and enable=0, so changing them mid-run has no effect. wr_ptr_o clears to 0 on that same sample.
- rd_ptr_i changing during a burst has no effect until the next IDLE evaluation.
- err_ring_full clears only on reset.

Optional Feature:
AUDIO_WR_STATS_EN:
- Defined: adds outputs stat_bursts (32b) and stat_full_stalls (32b). stat_bursts increments in ADV. stat_full_stalls increments each IDLE cycle with enable & burst_avail & full. Both are saturating and cleared by reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared defines: `MEM_WR_BL, `DSIZE, and a state encoding (IDLE=0, CMD=1, DATA=2, ADV=3).
- Sub-module: ring_ptr_wrap, which provides the wrap increment and the full compare. It is reusable by the camera write controller.
- Single FSM in the top module.

Test Plan:
- Single burst: base=0x100, ring=4, rd_ptr=0, burst_avail=1, rdy always 1. Expect cmd addr 0x100, then 16 data beats with last on beat 16, 16 burst_rd_en pulses, and wr_ptr_o=1.
- Wrap: ring=4, run 4 bursts with rd_ptr_i advanced. Expect addresses 0x100, 0x110, 0x120, 0x130, then 0x100, and wr_ptr_o back to 0.
- Full stall: ring=4, rd_ptr_i=0 fixed, 3 bursts written. The 4th is held in IDLE and err_ring_full=1. Setting rd_ptr_i=1 lets the burst proceed.
- Backpressure: mem_cmd_rdy low 5 cycles, then mem_wr_rdy toggling 1/0. Expect addr stable, data passthrough, burst_rd_en only on rdy cycles, exactly 16 pops.
- Enable drop: deassert enable at beat 5. Expect all 16 beats, ADV, then IDLE with no further cmd despite burst_avail=1.
- Reset mid-DATA: rst_n=0 at beat 8. Next cycle all outputs are 0, state IDLE, wr_ptr_o=0.

Source files
------------

// File: rtl/audio_burst_wr_ctrl_pkg.sv
// Purpose: shared defines and FSM state encoding for the audio burst write controller.
// Latency: n/a (constants only).
// Backpressure: n/a.
`ifndef MEM_WR_BL
`define MEM_WR_BL 16
`endif
`ifndef DSIZE
`define DSIZE 36
`endif

package audio_burst_wr_ctrl_pkg;

  localparam int STATE_W = 2;

  // Sequencer states; encoding is fixed so external debug taps can decode it.
  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_CMD  = 2'd1;
  localparam logic [STATE_W-1:0] ST_DATA = 2'd2;
  localparam logic [STATE_W-1:0] ST_ADV  = 2'd3;

endpackage

// File: rtl/audio_burst_wr_ctrl_ring_ptr_wrap.sv
// Purpose: ring pointer wrap-increment and ring-full compare (shared with camera write path).
// Latency: purely combinational, zero cycles.
// Backpressure: none; caller decides when to consume ptr_next.
module ring_ptr_wrap #(
  parameter int PTR_W = 10
) (
  input  logic [PTR_W-1:0] ptr,
  input  logic [PTR_W-1:0] ring_size,
  input  logic [PTR_W-1:0] rd_ptr,
  output logic [PTR_W-1:0] ptr_next,
  output logic             full
);

  // Wrap to slot 0 after the last slot of the ring; valid for ptr < ring_size.
  assign ptr_next = (ptr == ring_size - 1'b1) ? '0 : ptr + 1'b1;

  // One more burst would land on the consumer's current slot.
  assign full = (ptr_next == rd_ptr);

endmodule

// File: rtl/audio_burst_wr_ctrl.sv
// Purpose: drains full bursts from the audio FWFT burst FIFO into a circular PCM ring in memory.
// Latency: cmd one cycle after a burst is seen in IDLE; data is a zero-latency passthrough of the FIFO head.
// Backpressure: cmd held until mem_cmd_rdy; FIFO popped only on mem_wr_rdy; stalls in IDLE on ring full.
// Optional: define AUDIO_WR_STATS_EN to add the stat_bursts / stat_full_stalls counters.
module audio_burst_wr_ctrl
  import audio_burst_wr_ctrl_pkg::*;
#(
  parameter int BURST_LEN = `MEM_WR_BL,
  parameter int DSIZE     = `DSIZE,
  parameter int ADDR_W    = 21,
  parameter int PTR_W     = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [PTR_W-1:0]  ring_bursts,
  input  logic [PTR_W-1:0]  rd_ptr_i,
  input  logic              burst_avail,
  output logic              burst_rd_en,
  input  logic [DSIZE-1:0]  burst_rd_data,
  output logic              mem_cmd_vld,
  input  logic              mem_cmd_rdy,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  output logic              mem_wr_vld,
  input  logic              mem_wr_rdy,
  output logic [DSIZE-1:0]  mem_wr_data,
  output logic              mem_wr_last,
  output logic [PTR_W-1:0]  wr_ptr_o,
  output logic              busy,
`ifdef AUDIO_WR_STATS_EN
  output logic [31:0]       stat_bursts,
  output logic [31:0]       stat_full_stalls,
`endif
  output logic              err_ring_full
);

  // BURST_LEN is a power of two, so slot-to-address is a shift.
  localparam int BEAT_SHIFT = $clog2(BURST_LEN);
  localparam int CNT_W      = (BEAT_SHIFT > 0) ? BEAT_SHIFT : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

  logic [STATE_W-1:0] state_q;
  logic [CNT_W-1:0]   beat_cnt_q;
  logic [ADDR_W-1:0]  base_q;
  logic [PTR_W-1:0]   ring_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   wr_ptr_next;
  logic [ADDR_W-1:0]  cmd_addr_calc;
  logic               ring_full;
  logic               err_q;
  logic               sample_cfg;
  logic               burst_req;
  logic               beat_acc;
  logic               last_beat;

  ring_ptr_wrap #(
    .PTR_W(PTR_W)
  ) u_ring_ptr_wrap (
    .ptr       (wr_ptr_q),
    .ring_size (ring_q),
    .rd_ptr    (rd_ptr_i),
    .ptr_next  (wr_ptr_next),
    .full      (ring_full)
  );

  // Config is only taken while parked and disabled, so a live run never sees it change.
  assign sample_cfg = (state_q == ST_IDLE) && !enable;
  assign burst_req  = (state_q == ST_IDLE) && enable && burst_avail;
  assign beat_acc   = (state_q == ST_DATA) && mem_wr_rdy;
  assign last_beat  = beat_acc && (beat_cnt_q == CNT_LAST);

  assign cmd_addr_calc = base_q + (ADDR_W'(wr_ptr_q) << BEAT_SHIFT);

  assign mem_cmd_vld   = (state_q == ST_CMD);
  assign mem_cmd_addr  = (state_q == ST_CMD) ? cmd_addr_calc : '0;
  assign mem_wr_vld    = (state_q == ST_DATA);
  assign mem_wr_data   = (state_q == ST_DATA) ? burst_rd_data : '0;
  assign mem_wr_last   = (state_q == ST_DATA) && (beat_cnt_q == CNT_LAST);
  assign burst_rd_en   = beat_acc;
  assign wr_ptr_o      = wr_ptr_q;
  assign busy          = (state_q != ST_IDLE);
  assign err_ring_full = err_q;

  // Burst sequencer: IDLE -> CMD -> DATA -> ADV -> IDLE, never back-to-back.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (burst_req && !ring_full) state_q <= ST_CMD;
        ST_CMD:  if (mem_cmd_rdy)             state_q <= ST_DATA;
        ST_DATA: if (last_beat)               state_q <= ST_ADV;
        ST_ADV:                               state_q <= ST_IDLE;
        default:                              state_q <= ST_IDLE;
      endcase
    end
  end

  // Beat counter, ring write pointer and latched ring geometry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
      wr_ptr_q   <= '0;
      base_q     <= '0;
      ring_q     <= '0;
    end else begin
      if (state_q == ST_ADV) begin
        beat_cnt_q <= '0;
        wr_ptr_q   <= wr_ptr_next;
      end else if (beat_acc) begin
        beat_cnt_q <= beat_cnt_q + 1'b1;
      end
      if (sample_cfg) begin
        base_q   <= base_addr;
        ring_q   <= ring_bursts;
        wr_ptr_q <= '0;
      end
    end
  end

  // Sticky overrun flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (burst_req && ring_full) begin
      err_q <= 1'b1;
    end
  end

`ifdef AUDIO_WR_STATS_EN
  // Saturating burst and full-stall counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_bursts      <= '0;
      stat_full_stalls <= '0;
    end else begin
      if ((state_q == ST_ADV) && (stat_bursts != '1)) begin
        stat_bursts <= stat_bursts + 32'd1;
      end
      if (burst_req && ring_full && (stat_full_stalls != '1)) begin
        stat_full_stalls <= stat_full_stalls + 32'd1;
      end
    end
  end
`endif

endmodule
